btn_debounce_repeat: RTL and testbench
======================================

BTN_DEBOUNCE_REPEAT -- requirements
Module: btn_debounce_repeat

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000, consecutive stable clk cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_DELAY_CYC, default 50000000, cycles from accepted press to first auto-repeat pulse (500 ms).
REQ-003 Parameter REPEAT_PERIOD_CYC, default 10000000, cycles between successive auto-repeat pulses (100 ms).
REQ-004 Parameter PULSE_CYC, default 4, high width of every step pulse, in cycles; legal range is 1 to REPEAT_PERIOD_CYC-1.
REQ-005 clk  input  1  system clock, same domain as the digipot button controller.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 btns_raw  input  4  asynchronous, bouncing board buttons BTN0..BTN3, active-high.
REQ-008 btns_out  output  4  conditioned buttons driving the digipot controller btns port.
REQ-009 btns_level  output  4  debounced level of each button.

Function
REQ-010 Each bit of btns_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL hold a debounced level and a 32-bit stability counter; counter clears whenever synced input equals the debounced level.
REQ-012 When synced input differs from the debounced level for DEBOUNCE_CYC consecutive cycles, the debounced level SHALL flip and the counter SHALL clear; any intermediate match restarts the count.
REQ-013 btns_level[i] SHALL equal the debounced level; latency from a clean raw edge to btns_level is 2 + DEBOUNCE_CYC cycles.
REQ-014 btns_out[3:2] SHALL equal btns_level[3:2].
REQ-015 Channels 0 and 1 SHALL each run a step FSM with the states IDLE, PULSE, DELAY, PERIOD, plus a 32-bit timer and a pulse-width counter.
REQ-016 In IDLE, a debounced rising edge SHALL enter PULSE, assert btns_out[i] for PULSE_CYC cycles, and load the timer with REPEAT_DELAY_CYC.
REQ-017 After the first pulse the FSM SHALL go to DELAY.
REQ-018 When the DELAY timer expires, the FSM SHALL emit a pulse, reload the timer with REPEAT_PERIOD_CYC, and enter PERIOD.
REQ-019 Each PERIOD timer expiry SHALL emit one pulse and reload the timer.
REQ-020 The timer SHALL count from the start of each pulse, so pulse starts are exactly REPEAT_PERIOD_CYC apart.
REQ-021 A debounced release in any state SHALL return the FSM to IDLE.
REQ-022 An in-progress pulse SHALL complete its full PULSE_CYC width before btns_out[i] falls; no truncated pulses.
REQ-023 btns_out[i] SHALL be low for at least 1 cycle between consecutive pulses so downstream edge detection sees each one.
REQ-024 While btns_level[0] and btns_level[1] are both 1, neither channel SHALL start a new pulse.
REQ-025 When that inhibit ends with one button still held, that channel SHALL resume in DELAY with a fresh REPEAT_DELAY_CYC and no immediate pulse.
REQ-026 Timers SHALL saturate at 0 and never wrap; one pulse per expiry.
REQ-027 Channels SHALL be independent apart from REQ-024.

Reset
REQ-028 While resetn=0 at a clk edge, all synchronizer flops, debounced levels, counters and timers SHALL clear to 0.
REQ-029 While resetn=0, step FSMs SHALL be IDLE, and btns_out and btns_level SHALL be 4'b0000 from the first clocked reset cycle.
REQ-030 Reset asserted mid-pulse SHALL drop btns_out low on the next edge.
REQ-031 A button held through reset release SHALL be debounced afresh and produce one initial pulse after 2+DEBOUNCE_CYC cycles.

Verification (bench parameters: DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=40, REPEAT_PERIOD_CYC=10, PULSE_CYC=2)
REQ-032 btns_raw[1] toggles every 3 cycles for 30 cycles, then stays 0 -> btns_out and btns_level stay 0.
REQ-033 Clean press of btns_raw[1] held 35 cycles -> btns_level[1] rises 10 cycles after the edge; exactly one 2-cycle btns_out[1] pulse; no repeat.
REQ-034 btns_raw[0] held 100 cycles -> pulses start at t0, t0+40, t0+50, t0+60... each 2 cycles wide; output goes low on debounced release.
REQ-035 btns_raw[0] held, btns_raw[1] pressed 20 cycles later -> no pulses while both are debounced high; after btns_raw[1] releases, the next btns_out[0] pulse comes 40 cycles after the inhibit ends.
REQ-036 btns_raw[3] press and release -> btns_out[3] mirrors btns_level[3] with no pulses; resetn=0 during a btns_out[0] pulse -> btns_out=0 next cycle.

Source files
------------

// File: rtl/btn_debounce_repeat.sv
// Board button conditioner for the digipot controller.
// Every raw button is synchronized and debounced. BTN0/BTN1 become step
// pulses with press-and-hold auto-repeat; BTN2/BTN3 pass their debounced level.
// Holding BTN0 and BTN1 together suppresses stepping on both channels.
module btn_debounce_repeat #(
    parameter int unsigned DEBOUNCE_CYC      = 1000000,
    parameter int unsigned REPEAT_DELAY_CYC  = 50000000,
    parameter int unsigned REPEAT_PERIOD_CYC = 10000000,
    parameter int unsigned PULSE_CYC         = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] btns_raw,
    output logic [3:0] btns_out,
    output logic [3:0] btns_level
);

    localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] DELAY_LOAD  = 32'(REPEAT_DELAY_CYC);
    localparam logic [31:0] PERIOD_LOAD = 32'(REPEAT_PERIOD_CYC);
    localparam logic [31:0] PW_LOAD     = 32'(PULSE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        DELAY  = 2'd2,
        PERIOD = 2'd3
    } step_state_e;

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  level_q;
    logic [3:0]  level_d;
    logic [31:0] cnt_q [4];
    logic [31:0] cnt_d [4];
    logic        inhibit;
    logic [1:0]  step_out;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btns_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: a mismatch must persist DEBOUNCE_CYC cycles to flip the level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Debounced level and stability counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both step buttons held: the current and previous level are both
    // considered so the cycle on which the inhibit lifts still reloads the
    // delay, giving a full REPEAT_DELAY_CYC before the next pulse.
    assign inhibit = (level_d[0] & level_d[1]) | (level_q[0] & level_q[1]);

    for (genvar g = 0; g < 2; g++) begin : g_step
        step_state_e state_q;
        logic [31:0] timer_q;
        logic [31:0] pw_q;
        logic        out_q;

        // Step sequencer: first pulse on press, repeats after delay/period,
        // pulses always finish their full width even after release.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q <= IDLE;
                timer_q <= '0;
                pw_q    <= '0;
                out_q   <= 1'b0;
            end else begin
                if (pw_q > 32'd1) begin
                    pw_q <= pw_q - 32'd1;
                end else if (pw_q == 32'd1) begin
                    pw_q  <= '0;
                    out_q <= 1'b0;
                end

                if (timer_q != '0) begin
                    timer_q <= timer_q - 32'd1;
                end

                if (!level_d[g]) begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (inhibit) begin
                                state_q <= DELAY;
                                timer_q <= DELAY_LOAD;
                            end else if (pw_q == '0) begin
                                state_q <= PULSE;
                                timer_q <= DELAY_LOAD;
                                pw_q    <= PW_LOAD;
                                out_q   <= 1'b1;
                            end
                        end
                        PULSE: begin
                            if (inhibit) begin
                                timer_q <= DELAY_LOAD;
                            end
                            if (pw_q < 32'd2) begin
                                state_q <= DELAY;
                            end
                        end
                        DELAY, PERIOD: begin
                            if (inhibit) begin
                                state_q <= DELAY;
                                timer_q <= DELAY_LOAD;
                            end else if (timer_q < 32'd2) begin
                                state_q <= PERIOD;
                                timer_q <= PERIOD_LOAD;
                                pw_q    <= PW_LOAD;
                                out_q   <= 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end

        assign step_out[g] = out_q;
    end

    assign btns_level = level_q;
    assign btns_out   = {level_q[3:2], step_out};

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench for btn_debounce_repeat with a cycle-indexed reference model.
module tb_btn_debounce_repeat;

    localparam int D   = 8;
    localparam int DLY = 40;
    localparam int PER = 10;
    localparam int PW  = 2;
    localparam int HN  = 16384;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] btns_raw = 4'b0000;
    logic [3:0] btns_out;
    logic [3:0] btns_level;

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    int         cyc = 100;
    logic [3:0] hist [HN];
    logic [3:0] m_lvl = 4'b0000;
    logic [3:0] m_lvl_prev = 4'b0000;
    logic [3:0] m_out = 4'b0000;
    int         active [2];
    int         pend [2];
    int         nxt [2];

    btn_debounce_repeat #(
        .DEBOUNCE_CYC(D),
        .REPEAT_DELAY_CYC(DLY),
        .REPEAT_PERIOD_CYC(PER),
        .PULSE_CYC(PW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .btns_raw(btns_raw),
        .btns_out(btns_out),
        .btns_level(btns_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", ntests);
        $fatal(1, "watchdog");
    end

    // Model: level follows the synced input once it has been constant for D
    // samples; step pulses are scheduled as absolute cycle numbers.
    task automatic model_update();
        int  ones;
        logic inh;
        cyc++;
        m_lvl_prev = m_lvl;
        if (!resetn) begin
            hist[cyc % HN] = 4'b0000;
            m_lvl = 4'b0000;
            for (int c = 0; c < 2; c++) begin
                active[c] = 0;
                pend[c]   = 0;
                nxt[c]    = 0;
            end
        end else begin
            hist[cyc % HN] = btns_raw;
            for (int b = 0; b < 4; b++) begin
                ones = 0;
                for (int k = 2; k <= D + 1; k++) begin
                    if (hist[(cyc - k) % HN][b]) ones++;
                end
                if (ones == D) m_lvl[b] = 1'b1;
                else if (ones == 0) m_lvl[b] = 1'b0;
            end
            inh = (m_lvl[0] & m_lvl[1]) | (m_lvl_prev[0] & m_lvl_prev[1]);
            for (int c = 0; c < 2; c++) begin
                if (!m_lvl[c]) begin
                    active[c] = 0;
                end else if (active[c] == 0) begin
                    active[c] = 1;
                    nxt[c] = cyc + DLY;
                    if (!inh) pend[c] = cyc + PW;
                end else if (inh) begin
                    nxt[c] = cyc + DLY;
                end else if (cyc == nxt[c]) begin
                    pend[c] = cyc + PW;
                    nxt[c]  = cyc + PER;
                end
            end
        end
        m_out = {m_lvl[3:2], (pend[1] > cyc), (pend[0] > cyc)};
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btns_raw = 4'($urandom);
            tick();
            ntests++;
            if (btns_out !== 4'b0000 || btns_level !== 4'b0000) begin
                nfail++;
                $display("FAIL reset_state i=%0d out=%b lvl=%b want 0000/0000", i, btns_out, btns_level);
            end
        end
        btns_raw = 4'b0000;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL reset_idle i=%0d out=%b/%b lvl=%b/%b", i, btns_out, m_out, btns_level, m_lvl);
            end
        end
    endtask

    task automatic test_bounce();
        for (int j = 0; j < 50; j++) begin
            if (j < 30) btns_raw = (((j / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
            else btns_raw = 4'b0000;
            tick();
            ntests++;
            if (btns_out !== 4'b0000 || btns_level !== 4'b0000 || m_out !== 4'b0000) begin
                nfail++;
                $display("FAIL bounce j=%0d out=%b lvl=%b model=%b want 0000", j, btns_out, btns_level, m_out);
            end
        end
    endtask

    task automatic test_single_press();
        int   rise_at = -1;
        int   starts = 0;
        int   hi = 0;
        logic prev = 1'b0;
        btns_raw = 4'b0010;
        for (int j = 1; j <= 60; j++) begin
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL single_model j=%0d out=%b/%b lvl=%b/%b", j, btns_out, m_out, btns_level, m_lvl);
            end
            if (rise_at < 0 && btns_level[1]) rise_at = j;
            if (btns_out[1] && !prev) starts++;
            if (btns_out[1]) hi++;
            prev = btns_out[1];
            if (j == 35) btns_raw = 4'b0000;
        end
        ntests++;
        if (rise_at !== D + 2) begin
            nfail++;
            $display("FAIL single_latency got=%0d want=%0d", rise_at, D + 2);
        end
        ntests++;
        if (starts !== 1 || hi !== PW) begin
            nfail++;
            $display("FAIL single_pulse pulses=%0d width=%0d want 1/%0d", starts, hi, PW);
        end
    endtask

    task automatic test_auto_repeat();
        int   st [$];
        int   hi = 0;
        int   want;
        logic prev = 1'b0;
        btns_raw = 4'b0001;
        for (int j = 1; j <= 140; j++) begin
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL repeat_model j=%0d out=%b/%b lvl=%b/%b", j, btns_out, m_out, btns_level, m_lvl);
            end
            if (btns_out[0] && !prev) st.push_back(j);
            if (btns_out[0]) hi++;
            prev = btns_out[0];
            if (j == 100) btns_raw = 4'b0000;
        end
        ntests++;
        if (st.size() !== 7 || hi !== 7 * PW) begin
            nfail++;
            $display("FAIL repeat_count pulses=%0d high=%0d want 7/%0d", st.size(), hi, 7 * PW);
        end
        for (int k = 0; k < st.size() && k < 7; k++) begin
            want = (k == 0) ? D + 2 : D + 2 + DLY + PER * (k - 1);
            ntests++;
            if (st[k] !== want) begin
                nfail++;
                $display("FAIL repeat_start k=%0d got=%0d want=%0d", k, st[k], want);
            end
        end
        ntests++;
        if (btns_out !== 4'b0000) begin
            nfail++;
            $display("FAIL repeat_release out=%b want 0000", btns_out);
        end
    endtask

    task automatic test_inhibit();
        int   st [$];
        int   fall_at = -1;
        int   ch1_hi = 0;
        int   inh_pulses = 0;
        logic prev = 1'b0;
        logic prev_l1 = 1'b0;
        btns_raw = 4'b0001;
        for (int j = 1; j <= 150; j++) begin
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL inhibit_model j=%0d out=%b/%b lvl=%b/%b", j, btns_out, m_out, btns_level, m_lvl);
            end
            if (btns_out[0] && !prev) begin
                st.push_back(j);
                if (btns_level[0] && btns_level[1]) inh_pulses++;
            end
            if (btns_out[1]) ch1_hi++;
            if (fall_at < 0 && prev_l1 && !btns_level[1]) fall_at = j;
            prev = btns_out[0];
            prev_l1 = btns_level[1];
            if (j == 20) btns_raw = 4'b0011;
            if (j == 50) btns_raw = 4'b0001;
            if (j == 120) btns_raw = 4'b0000;
        end
        ntests++;
        if (inh_pulses !== 0 || ch1_hi !== 0) begin
            nfail++;
            $display("FAIL inhibit_quiet ch0_inhibited=%0d ch1_high=%0d want 0/0", inh_pulses, ch1_hi);
        end
        ntests++;
        if (st.size() !== 4 || fall_at !== 60) begin
            nfail++;
            $display("FAIL inhibit_count pulses=%0d l1_fall=%0d want 4/60", st.size(), fall_at);
        end else begin
            ntests++;
            if (st[1] - fall_at !== DLY) begin
                nfail++;
                $display("FAIL inhibit_resume gap=%0d want=%0d", st[1] - fall_at, DLY);
            end
        end
    endtask

    task automatic test_mirror_and_reset();
        int hi3 = 0;
        int found = 0;
        int rise_at = -1;
        int first_start = -1;
        btns_raw = 4'b1000;
        for (int j = 1; j <= 40; j++) begin
            tick();
            ntests++;
            if (btns_out[3] !== btns_level[3] || btns_out[2:0] !== 3'b000 || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL mirror j=%0d out=%b lvl=%b model_lvl=%b", j, btns_out, btns_level, m_lvl);
            end
            if (btns_out[3]) hi3++;
            if (j == 20) btns_raw = 4'b0000;
        end
        ntests++;
        if (hi3 !== 20) begin
            nfail++;
            $display("FAIL mirror_width got=%0d want=20", hi3);
        end
        btns_raw = 4'b0001;
        for (int j = 1; j <= 30 && found == 0; j++) begin
            tick();
            if (btns_out[0]) found = j;
        end
        ntests++;
        if (found == 0) begin
            nfail++;
            $display("FAIL midpulse_wait no pulse within 30 cycles want one");
        end
        resetn = 1'b0;
        tick();
        ntests++;
        if (btns_out !== 4'b0000 || btns_level !== 4'b0000) begin
            nfail++;
            $display("FAIL midpulse_reset out=%b lvl=%b want 0000/0000", btns_out, btns_level);
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL held_model j=%0d out=%b/%b lvl=%b/%b", j, btns_out, m_out, btns_level, m_lvl);
            end
            if (rise_at < 0 && btns_level[0]) rise_at = j;
            if (first_start < 0 && btns_out[0]) first_start = j;
        end
        ntests++;
        if (rise_at !== D + 2 || first_start !== D + 2) begin
            nfail++;
            $display("FAIL held_reset rise=%0d pulse=%0d want %0d/%0d", rise_at, first_start, D + 2, D + 2);
        end
        btns_raw = 4'b0000;
        for (int j = 0; j < 20; j++) tick();
    endtask

    task automatic test_random();
        int rst_left = 0;
        int odds;
        for (int j = 0; j < 3000; j++) begin
            odds = (j < 1500) ? 11 : 70;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, odds) == 0) btns_raw[b] = ~btns_raw[b];
            end
            if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = 3;
            if (rst_left > 0) begin
                resetn = 1'b0;
                rst_left--;
            end else begin
                resetn = 1'b1;
            end
            tick();
            ntests++;
            if (btns_out !== m_out || btns_level !== m_lvl) begin
                nfail++;
                $display("FAIL random j=%0d raw=%b out=%b/%b lvl=%b/%b", j, btns_raw, btns_out, m_out, btns_level, m_lvl);
            end
        end
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < HN; i++) hist[i] = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            active[c] = 0;
            pend[c]   = 0;
            nxt[c]    = 0;
        end
        #1;
        test_reset();
        test_bounce();
        test_single_press();
        test_auto_repeat();
        test_inhibit();
        test_mirror_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
